pe_array_ctrl: RTL and testbench

Sequencer for a ROWS x COLS systolic array of pe tiles. Runs one matrix job per start pulse: clear accumulators, stream k_len operand beats (dense or sparse/NZET), flush the array skew, then shift accumulated psums out the bottom row. It drives the shared en/mode/mode_nzet broadcast to every pe, gates the operand feeder, and frames the drained results.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_array_ctrl_if.sv | 31 +++
 rtl/pe_ctrl_cnt.sv | 38 +++
 rtl/pe_array_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the pe tile and its array controller: broadcast modes and sequencer
// states.
package pe_pkg;

    localparam logic [1:0] ModeDenden = 2'b00;
    localparam logic [1:0] ModeSpaden = 2'b01;
    localparam logic [1:0] ModeShift  = 2'b10;
    localparam logic [1:0] ModeWait   = 2'b11;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t StIdle    = 3'd0;
    localparam ctrl_state_t StClear   = 3'd1;
    localparam ctrl_state_t StCompute = 3'd2;
    localparam ctrl_state_t StFlush   = 3'd3;
    localparam ctrl_state_t StDrain   = 3'd4;
    localparam ctrl_state_t StDone    = 3'd5;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Job request, feeder handshake and pe broadcast bundle of the array controller.
interface pe_array_ctrl_if #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned KLEN_W = 16
);
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic              start;
    logic              sparse;
    logic [KLEN_W-1:0] k_len;
    logic              stall;
    logic              busy;
    logic              done;
    logic              pe_en;
    logic [1:0]        pe_mode;
    logic              pe_mode_nzet;
    logic              feed_valid;
    logic              drain_valid;
    logic [RowW-1:0]   drain_row;

    modport master (
        output start, sparse, k_len, stall,
        input  busy, done, pe_en, pe_mode, pe_mode_nzet, feed_valid, drain_valid, drain_row
    );

    modport slave (
        input  start, sparse, k_len, stall,
        output busy, done, pe_en, pe_mode, pe_mode_nzet, feed_valid, drain_valid, drain_row
    );

endinterface

// File: rtl/pe_ctrl_cnt.sv
// Loadable down-counter with hold; load wins over decrement. Exposes a zero flag and the
// low bits used as the drain row index.
module pe_ctrl_cnt #(
    parameter int unsigned Width = 16,
    parameter int unsigned LowW  = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o,
    output logic [LowW-1:0] low_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign low_o  = cnt_q[LowW-1:0];

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array: clear, stream k_len beats, flush skew,
// shift psums out of the bottom row.
module pe_array_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned KLEN_W = 16
) (
    input logic             clock,
    input logic             reset_n,
    pe_array_ctrl_if.slave  bus
);

    localparam int unsigned FlushLen = ROWS + COLS - 2;
    localparam int unsigned RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CntW     =
        max_u(KLEN_W, max_u($clog2(FlushLen + 1), $clog2(ROWS + 1)));

    // Counter is loaded with length-1 so each phase ends on the zero flag.
    localparam logic [CntW-1:0] FlushLd = (FlushLen == 0) ? '0 : CntW'(FlushLen - 1);
    localparam logic [CntW-1:0] DrainLd = CntW'(ROWS - 1);

    ctrl_state_t       state_q, state_d;
    logic              sparse_q, sparse_d;
    logic [KLEN_W-1:0] klen_q, klen_d;
    logic [KLEN_W-1:0] klen_m1;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CntW-1:0]   cnt_val;
    logic [RowW-1:0]   cnt_low;

    assign klen_m1 = klen_q - KLEN_W'(1);

    pe_ctrl_cnt #(
        .Width (CntW),
        .LowW  (RowW)
    ) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .low_o      (cnt_low)
    );

    always_comb begin
        state_d  = state_q;
        sparse_d = sparse_q;
        klen_d   = klen_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sparse_d = bus.sparse;
                    klen_d   = bus.k_len;
                    state_d  = StClear;
                end
            end
            StClear: begin
                cnt_load = 1'b1;
                if (klen_q != '0) begin
                    cnt_val = CntW'(klen_m1);
                    state_d = StCompute;
                end else begin
                    cnt_val = DrainLd;
                    state_d = StDrain;
                end
            end
            StCompute: begin
                if (!bus.stall) begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        if (FlushLen == 0) begin
                            cnt_val = DrainLd;
                            state_d = StDrain;
                        end else begin
                            cnt_val = FlushLd;
                            state_d = StFlush;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = DrainLd;
                    state_d  = StDrain;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDrain: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            sparse_q <= 1'b0;
            klen_q   <= '0;
        end else begin
            state_q  <= state_d;
            sparse_q <= sparse_d;
            klen_q   <= klen_d;
        end
    end

    // Outputs decode only registered state; stall gates the feed within the same beat.
    always_comb begin
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.pe_en        = 1'b0;
        bus.pe_mode      = ModeWait;
        bus.pe_mode_nzet = 1'b0;
        bus.feed_valid   = 1'b0;
        bus.drain_valid  = 1'b0;
        bus.drain_row    = '0;
        case (state_q)
            StClear: begin
                bus.busy         = 1'b1;
                bus.pe_mode_nzet = sparse_q;
            end
            StCompute: begin
                bus.busy         = 1'b1;
                bus.pe_en        = 1'b1;
                bus.pe_mode_nzet = sparse_q;
                if (!bus.stall) begin
                    bus.pe_mode    = sparse_q ? ModeSpaden : ModeDenden;
                    bus.feed_valid = 1'b1;
                end
            end
            StFlush: begin
                bus.busy         = 1'b1;
                bus.pe_en        = 1'b1;
                bus.pe_mode_nzet = sparse_q;
                bus.pe_mode      = sparse_q ? ModeSpaden : ModeDenden;
            end
            StDrain: begin
                bus.busy         = 1'b1;
                bus.pe_en        = 1'b1;
                bus.pe_mode_nzet = sparse_q;
                bus.pe_mode      = ModeShift;
                bus.drain_valid  = 1'b1;
                bus.drain_row    = cnt_low;
            end
            StDone: begin
                bus.busy         = 1'b1;
                bus.done         = 1'b1;
                bus.pe_mode_nzet = sparse_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed cycle tables for a 4x4 controller, plus hand-written async-reset sequences.
module tb_pe_array_ctrl;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pe_array_ctrl_if #(.ROWS(4), .KLEN_W(16)) bus ();

    pe_array_ctrl #(
        .ROWS   (4),
        .COLS   (4),
        .KLEN_W (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Expected word: {busy, done, pe_en, pe_mode[1:0], nzet, feed_valid, drain_valid, row[1:0]}
    typedef struct {
        logic        start;
        logic        sparse;
        logic [15:0] klen;
        logic        stall;
        logic [9:0]  exp;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [9:0] pk(input logic busy, input logic done, input logic en,
                                      input logic [1:0] mode, input logic nzet,
                                      input logic feed, input logic dv, input logic [1:0] row);
        return {busy, done, en, mode, nzet, feed, dv, row};
    endfunction

    localparam logic [9:0] Idle = 10'b00_0_11_0_0_0_00;

    function automatic logic [9:0] e_clear(input logic nz);
        return pk(1, 0, 0, 2'b11, nz, 0, 0, 2'd0);
    endfunction
    function automatic logic [9:0] e_comp(input logic nz);
        return pk(1, 0, 1, {1'b0, nz}, nz, 1, 0, 2'd0);
    endfunction
    function automatic logic [9:0] e_stall(input logic nz);
        return pk(1, 0, 1, 2'b11, nz, 0, 0, 2'd0);
    endfunction
    function automatic logic [9:0] e_flush(input logic nz);
        return pk(1, 0, 1, {1'b0, nz}, nz, 0, 0, 2'd0);
    endfunction
    function automatic logic [9:0] e_drain(input logic nz, input logic [1:0] r);
        return pk(1, 0, 1, 2'b10, nz, 0, 1, r);
    endfunction
    function automatic logic [9:0] e_done(input logic nz);
        return pk(1, 1, 0, 2'b11, nz, 0, 0, 2'd0);
    endfunction

    function automatic logic [9:0] outs();
        return {bus.busy, bus.done, bus.pe_en, bus.pe_mode, bus.pe_mode_nzet,
                bus.feed_valid, bus.drain_valid, bus.drain_row};
    endfunction

    task automatic add(input logic st, input logic sp, input logic [15:0] kl,
                       input logic sl, input logic [9:0] e);
        vec_t v;
        v.start = st; v.sparse = sp; v.klen = kl; v.stall = sl; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Dense k_len=5 job with start at cycle 0, no stalls; 19 cycles including trailing idle.
    task automatic build_job1();
        add(1, 0, 16'd5, 0, Idle);
        add(0, 0, 16'd5, 0, e_clear(0));
        for (int i = 0; i < 5; i++) add(0, 0, 16'd5, 0, e_comp(0));
        for (int i = 0; i < 6; i++) add(0, 0, 16'd5, 0, e_flush(0));
        for (int r = 3; r >= 0; r--) add(0, 0, 16'd5, 0, e_drain(0, 2'(r)));
        add(0, 0, 16'd5, 0, e_done(0));
        add(0, 0, 16'd5, 0, Idle);
    endtask

    task automatic play(input string name, output int feeds, output int drains);
        feeds  = 0;
        drains = 0;
        foreach (vq[i]) begin
            @(posedge clock);
            #1;
            bus.start  = vq[i].start;
            bus.sparse = vq[i].sparse;
            bus.k_len  = vq[i].klen;
            bus.stall  = vq[i].stall;
            @(negedge clock);
            total++;
            if (outs() !== vq[i].exp) begin
                bad++;
                $display("FAIL %s cycle %0d: got %b want %b", name, i, outs(), vq[i].exp);
            end
            if (bus.feed_valid === 1'b1) feeds++;
            if (bus.drain_valid === 1'b1) drains++;
        end
        vq.delete();
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        int feeds, drains, n_done, n_busy;

        bus.start  = 1'b0;
        bus.sparse = 1'b0;
        bus.k_len  = '0;
        bus.stall  = 1'b0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #2 chk("reset_init", 32'(outs()), 32'(Idle));
        #8 reset_n = 1'b1;

        build_job1();
        play("dense_k5", feeds, drains);
        chk("dense_k5_feeds", feeds, 5);
        chk("dense_k5_drains", drains, 4);

        // Sparse job, stall at cycles 3-4: compute stretches to cycle 8, done at 19.
        add(1, 1, 16'd5, 0, Idle);
        add(0, 0, 16'd5, 0, e_clear(1));
        add(0, 0, 16'd5, 0, e_comp(1));
        add(0, 0, 16'd5, 1, e_stall(1));
        add(0, 0, 16'd5, 1, e_stall(1));
        for (int i = 0; i < 4; i++) add(0, 0, 16'd5, 0, e_comp(1));
        for (int i = 0; i < 6; i++) add(0, 0, 16'd5, 0, e_flush(1));
        for (int r = 3; r >= 0; r--) add(0, 0, 16'd5, 0, e_drain(1, 2'(r)));
        add(0, 0, 16'd5, 0, e_done(1));
        add(0, 0, 16'd5, 0, Idle);
        play("sparse_stall", feeds, drains);
        chk("sparse_stall_feeds", feeds, 5);
        chk("sparse_stall_drains", drains, 4);

        // k_len=0 skips compute and flush, drains zeros.
        add(1, 0, 16'd0, 0, Idle);
        add(0, 0, 16'd0, 0, e_clear(0));
        for (int r = 3; r >= 0; r--) add(0, 0, 16'd0, 0, e_drain(0, 2'(r)));
        add(0, 0, 16'd0, 0, e_done(0));
        add(0, 0, 16'd0, 0, Idle);
        play("klen0", feeds, drains);
        chk("klen0_feeds", feeds, 0);

        // Starts at 5 and 17 ignored, stalls in flush/drain ignored, start at 18 accepted.
        build_job1();
        vq[5].start  = 1'b1;
        vq[5].sparse = 1'b1;
        vq[5].klen   = 16'd2;
        vq[8].stall  = 1'b1;
        vq[9].stall  = 1'b1;
        vq[14].stall = 1'b1;
        vq[17].start = 1'b1;
        vq[18].start = 1'b1;
        vq[18].klen  = 16'd0;
        add(0, 0, 16'd0, 0, e_clear(0));
        for (int r = 3; r >= 0; r--) add(0, 0, 16'd0, 1, e_drain(0, 2'(r)));
        add(0, 0, 16'd0, 0, e_done(0));
        add(0, 0, 16'd0, 0, Idle);
        play("ignore_start", feeds, drains);
        chk("ignore_start_feeds", feeds, 5);
        chk("ignore_start_drains", drains, 8);

        // Async reset in cycle 8 (mid-flush) of a dense job.
        build_job1();
        while (vq.size() > 8) void'(vq.pop_back());
        play("pre_reset", feeds, drains);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk("reset_async", 32'(outs()), 32'(Idle));
        @(posedge clock);
        #1 reset_n = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) n_done++;
            if (bus.busy === 1'b1) n_busy++;
        end
        chk("reset_no_done", n_done, 0);
        chk("reset_no_busy", n_busy, 0);

        build_job1();
        play("post_reset", feeds, drains);
        chk("post_reset_feeds", feeds, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
